// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the miniRV instruction fetch stage.
//   fetch_entry_t    - one buffered fetch: PC of the word and the word itself
//   RESET_PC_DEFAULT - PC loaded on reset unless the top is overridden
//   INST_BYTES       - PC increment per sequential fetch
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t between fetch and decode.
//   clk, rst_n     - clock, asynchronous active-low reset (storage zeroed)
//   push_i, wdata_i- enqueue one entry (ignored when full without a pop)
//   pop_i          - dequeue the head (caller only pops when not empty)
//   flush_i        - discard all entries; dominates push and pop
//   rdata_o        - head slot contents (last head slot when empty)
//   full_o, empty_o- occupancy flags
// Pointers carry an extra wrap bit so full and empty are distinguishable
// when the index bits match.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            do_push;
  logic            do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer indexes, so the overwrite is safe.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      // Empty the queue by catching the read pointer up to the write pointer.
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: miniRV instruction fetch stage.
//   clk, rst_n                - core clock, asynchronous active-low reset
//   rom_addr                  - ROM read address (the PC register)
//   rom_rdata                 - ROM word for rom_addr, same cycle
//   redirect_valid/redirect_pc- control-flow change from execute; flushes
//                               the queue and restarts fetch at the target
//   inst_valid/inst_ready     - head handshake toward decode
//   inst, inst_pc             - head instruction word and its PC
//   fetch_count               - instructions enqueued since reset (wraps)
// Handshake: an instruction transfers to decode on a rising edge where
// inst_valid && inst_ready; inst_valid/inst/inst_pc stay stable while
// inst_valid && !inst_ready unless a redirect flushes the queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic         q_full;
  logic         q_empty;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;

  assign pop  = !q_empty && inst_ready;
  // A redirect cancels this cycle's fetch: the word at pc is off-path.
  assign push = !redirect_valid && (!q_full || pop);

  assign wr_entry.pc   = pc_q;
  assign wr_entry.inst = rom_rdata;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i (wr_entry),
    .rdata_o (head_entry),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      pc_d    = pc_q + INST_BYTES;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign inst_valid  = !q_empty;
  assign inst        = head_entry.inst;
  assign inst_pc     = head_entry.pc;
  assign fetch_count = count_q;

endmodule
